branch_predictor: RTL and testbench

Fetch-stage gshare direction predictor plus direct-mapped branch target buffer. It consumes the resolved-branch update packet from the updater on `from_updater_to_predictor`. For each fetch PC it returns a predicted next PC and the prediction metadata (BHR snapshot, PHT index, PHT entry) that travels down the pipe to AGEX and back to the updater. It owns all predictor state: an 8-bit BHR, a 256 x 2-bit PHT and a 16-entry BTB.

---
 rtl/branch_predictor.sv | 170 +++++++++++++++++
 tb/tb_branch_predictor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor (8-bit BHR, 256 x 2-bit PHT)
// plus a 16-entry direct-mapped BTB for the fetch stage.
// Lookup is combinational from the table registers. Resolved-branch updates
// are applied at the clock edge once the post-reset PHT sweep has finished.
// Optional macro BP_BYPASS_EN: forward a same-cycle update into the lookup.
module branch_predictor #(
   parameter int         DBITS                           = 32,
   parameter int         from_updater_to_predictor_WIDTH = 82,
   parameter logic [1:0] PHT_INIT                        = 2'b01
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       fetch_valid,
   input  logic [DBITS-1:0]                           fetch_pc,
   input  logic [from_updater_to_predictor_WIDTH-1:0] from_updater_to_predictor,
   output logic                                       pred_taken,
   output logic [DBITS-1:0]                           pred_pc,
   output logic [7:0]                                 pred_bhr,
   output logic [7:0]                                 pred_pht_index,
   output logic [1:0]                                 pred_pht_entry,
   output logic                                       bp_ready
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t      state_q, state_d;
   logic [7:0]  init_idx_q, init_idx_d;
   logic [7:0]  bhr_q, bhr_d;
   logic [15:0] btb_valid_q, btb_valid_d;

   logic [1:0]  pht_q [256];
   logic [25:0] btb_tag_q [16];
   logic [31:0] btb_target_q [16];

   // Update packet fields
   logic        upd_is_branch;
   logic [7:0]  upd_bhr;
   logic [7:0]  upd_pht_index;
   logic [1:0]  upd_pht_entry;
   logic [3:0]  upd_btb_index;
   logic [25:0] upd_btb_tag;
   logic        upd_btb_valid;
   logic [31:0] upd_btb_target;
   logic        upd_fire;

   assign upd_is_branch  = from_updater_to_predictor[81];
   assign upd_bhr        = from_updater_to_predictor[80:73];
   assign upd_pht_index  = from_updater_to_predictor[72:65];
   assign upd_pht_entry  = from_updater_to_predictor[64:63];
   assign upd_btb_index  = from_updater_to_predictor[62:59];
   assign upd_btb_tag    = from_updater_to_predictor[58:33];
   assign upd_btb_valid  = from_updater_to_predictor[32];
   assign upd_btb_target = from_updater_to_predictor[31:0];

   // Updates are only accepted once the tables are initialised
   assign upd_fire = (state_q == ST_RUN) && upd_is_branch;

   // PC word-offset bits never take part in indexing or tagging
   logic unused_pc_bits;
   assign unused_pc_bits = ^fetch_pc[1:0];

   // Table write port and control state
   logic       pht_we;
   logic [7:0] pht_waddr;
   logic [1:0] pht_wdata;
   logic       btb_we;

   // Next-state: init sweep in INIT, resolved-branch updates in RUN
   always_comb begin
      state_d     = state_q;
      init_idx_d  = init_idx_q;
      bhr_d       = bhr_q;
      btb_valid_d = btb_valid_q;
      pht_we      = 1'b0;
      pht_waddr   = upd_pht_index;
      pht_wdata   = upd_pht_entry;
      btb_we      = 1'b0;
      case (state_q)
         ST_INIT: begin
            pht_we     = 1'b1;
            pht_waddr  = init_idx_q;
            pht_wdata  = PHT_INIT;
            init_idx_d = init_idx_q + 8'd1;
            if (init_idx_q == 8'hFF) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (upd_is_branch) begin
               bhr_d                      = upd_bhr;
               pht_we                     = 1'b1;
               btb_we                     = 1'b1;
               btb_valid_d[upd_btb_index] = upd_btb_valid;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Control registers: async active-low reset restarts the sweep
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_INIT;
         init_idx_q  <= 8'd0;
         bhr_q       <= 8'd0;
         btb_valid_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         init_idx_q  <= init_idx_d;
         bhr_q       <= bhr_d;
         btb_valid_q <= btb_valid_d;
      end
   end

   // Table storage: no reset, PHT is filled by the sweep, BTB gated by valid bits
   always_ff @(posedge clk) begin
      if (pht_we) begin
         pht_q[pht_waddr] <= pht_wdata;
      end
      if (btb_we) begin
         btb_tag_q[upd_btb_index]    <= upd_btb_tag;
         btb_target_q[upd_btb_index] <= upd_btb_target;
      end
   end

   logic [7:0]  look_bhr;
   logic [7:0]  look_idx;
   logic [3:0]  look_btb_i;
   logic [1:0]  look_pht;
   logic        look_valid;
   logic [25:0] look_tag;
   logic [31:0] look_target;
   logic        look_hit;
   logic        look_run;

   // Combinational lookup, optionally forwarding a same-cycle update
   always_comb begin
      look_run    = (state_q == ST_RUN);
      look_bhr    = bhr_q;
`ifdef BP_BYPASS_EN
      if (upd_fire) begin
         look_bhr = upd_bhr;
      end
`endif
      look_idx    = fetch_pc[9:2] ^ look_bhr;
      look_btb_i  = fetch_pc[5:2];
      look_pht    = pht_q[look_idx];
      look_valid  = btb_valid_q[look_btb_i];
      look_tag    = btb_tag_q[look_btb_i];
      look_target = btb_target_q[look_btb_i];
`ifdef BP_BYPASS_EN
      if (upd_fire && (upd_pht_index == look_idx)) begin
         look_pht = upd_pht_entry;
      end
      if (upd_fire && (upd_btb_index == look_btb_i)) begin
         look_valid  = upd_btb_valid;
         look_tag    = upd_btb_tag;
         look_target = upd_btb_target;
      end
`endif
      look_hit       = look_valid && (look_tag == fetch_pc[31:6]);
      pred_taken     = look_run && fetch_valid && look_hit && look_pht[1];
      pred_pc        = pred_taken ? DBITS'(look_target) : (fetch_pc + DBITS'(4));
      pred_bhr       = look_bhr;
      pred_pht_index = look_idx;
      pred_pht_entry = look_run ? look_pht : PHT_INIT;
      bp_ready       = look_run;
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [81:0] pkt;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic [7:0]  pred_bhr;
   logic [7:0]  pred_pht_index;
   logic [1:0]  pred_pht_entry;
   logic        bp_ready;

   int check_count = 0;
   int pass_count  = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk                       (clk),
      .reset                     (reset),
      .fetch_valid               (fetch_valid),
      .fetch_pc                  (fetch_pc),
      .from_updater_to_predictor (pkt),
      .pred_taken                (pred_taken),
      .pred_pc                   (pred_pc),
      .pred_bhr                  (pred_bhr),
      .pred_pht_index            (pred_pht_index),
      .pred_pht_entry            (pred_pht_entry),
      .bp_ready                  (bp_ready)
   );

   function automatic logic [81:0] mk_pkt(input logic br, input logic [7:0] bhr,
                                          input logic [7:0] pidx, input logic [1:0] pent,
                                          input logic [3:0] bidx, input logic [25:0] tag,
                                          input logic v, input logic [31:0] tgt);
      return {br, bhr, pidx, pent, bidx, tag, v, tgt};
   endfunction

   task automatic test_reset();
      reset       = 1'b1;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      pkt         = '0;
      #1 reset = 1'b0;
      #3;
      check_count++;
      if (bp_ready !== 1'b0) $display("FAIL reset_bp_ready: got %0b expected 0", bp_ready);
      else pass_count++;
      check_count++;
      if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %0b expected 0", pred_taken);
      else pass_count++;
      check_count++;
      if (pred_bhr !== 8'h00) $display("FAIL reset_pred_bhr: got %0h expected 0", pred_bhr);
      else pass_count++;
      check_count++;
      if (pred_pc !== 32'h104) $display("FAIL reset_pred_pc: got %0h expected 104", pred_pc);
      else pass_count++;
      check_count++;
      if (pred_pht_entry !== 2'b01) $display("FAIL reset_pht_entry: got %0b expected 01", pred_pht_entry);
      else pass_count++;
      $display("test_reset done: bp_ready=%0b pred_pc=%0h", bp_ready, pred_pc);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Sweep after reset release, with an update injected during INIT that must be dropped
   task automatic test_init_sweep();
      int cyc;
      int bad_pc;
      cyc    = 0;
      bad_pc = 0;
      while (!bp_ready && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
         if (pred_pc !== 32'h104) bad_pc++;
         if (cyc == 5) begin
            check_count++;
            if (pred_pht_entry !== 2'b01) $display("FAIL init_pht_entry: got %0b expected 01", pred_pht_entry);
            else pass_count++;
         end
         if (cyc == 9) pkt = mk_pkt(1'b1, 8'h55, 8'h40, 2'b11, 4'd0, 26'h4, 1'b1, 32'h2000);
         else pkt = '0;
      end
      check_count++;
      if (cyc !== 256) $display("FAIL init_ready_cycle: got %0d expected 256", cyc);
      else pass_count++;
      check_count++;
      if (bad_pc !== 0) $display("FAIL init_pred_pc: got %0d wrong cycles expected 0", bad_pc);
      else pass_count++;
      check_count++;
      if (pred_bhr !== 8'h00) $display("FAIL init_drop_bhr: got %0h expected 0", pred_bhr);
      else pass_count++;
      check_count++;
      if (pred_pht_entry !== 2'b01) $display("FAIL init_drop_pht: got %0b expected 01", pred_pht_entry);
      else pass_count++;
      check_count++;
      if (pred_taken !== 1'b0) $display("FAIL init_drop_taken: got %0b expected 0", pred_taken);
      else pass_count++;
      $display("test_init_sweep: ready after %0d cycles", cyc);
      for (int i = 0; i < 256; i++) begin
         fetch_pc = 32'(i) << 2;
         #1;
         check_count++;
         if (pred_pht_entry !== 2'b01 || pred_pht_index !== 8'(i))
            $display("FAIL pht_sweep[%0d]: got entry %0b idx %0h expected 01 idx %0h",
                     i, pred_pht_entry, pred_pht_index, i);
         else pass_count++;
      end
      $display("test_init_sweep: PHT sweep read back");
   endtask

   task automatic test_update_hit();
      @(negedge clk);
      fetch_pc = 32'h300;
      // fetch_pc 0x104: idx = 0x41 ^ 0x01 = 0x40, btb_i = 1, tag = 0x4
      pkt = mk_pkt(1'b1, 8'h01, 8'h40, 2'b11, 4'd1, 26'h4, 1'b1, 32'h2000);
      @(negedge clk);
      pkt      = '0;
      fetch_pc = 32'h104;
      #1;
      check_count++;
      if (pred_taken !== 1'b1) $display("FAIL hit_taken: got %0b expected 1", pred_taken);
      else pass_count++;
      check_count++;
      if (pred_pc !== 32'h2000) $display("FAIL hit_pred_pc: got %0h expected 2000", pred_pc);
      else pass_count++;
      check_count++;
      if (pred_bhr !== 8'h01) $display("FAIL hit_bhr: got %0h expected 01", pred_bhr);
      else pass_count++;
      check_count++;
      if (pred_pht_index !== 8'h40 || pred_pht_entry !== 2'b11)
         $display("FAIL hit_pht: got idx %0h entry %0b expected idx 40 entry 11", pred_pht_index, pred_pht_entry);
      else pass_count++;
      $display("test_update_hit: pc=104 taken=%0b pred_pc=%0h", pred_taken, pred_pc);
      fetch_pc = 32'h144;
      #1;
      check_count++;
      if (pred_taken !== 1'b0 || pred_pc !== 32'h148)
         $display("FAIL tag_miss: got taken %0b pc %0h expected 0 148", pred_taken, pred_pc);
      else pass_count++;
      check_count++;
      if (pred_pht_index !== 8'h50) $display("FAIL tag_miss_idx: got %0h expected 50", pred_pht_index);
      else pass_count++;
      fetch_pc    = 32'h104;
      fetch_valid = 1'b0;
      #1;
      check_count++;
      if (pred_taken !== 1'b0 || pred_pc !== 32'h108)
         $display("FAIL fetch_invalid: got taken %0b pc %0h expected 0 108", pred_taken, pred_pc);
      else pass_count++;
      fetch_valid = 1'b1;
      fetch_pc    = 32'hFFFF_FFFC;
      #1;
      check_count++;
      if (pred_taken !== 1'b0 || pred_pc !== 32'h0)
         $display("FAIL pc_wrap: got taken %0b pc %0h expected 0 0", pred_taken, pred_pc);
      else pass_count++;
      $display("test_update_hit: miss/invalid/wrap lookups done");
      // Weakly taken counter still predicts taken
      @(negedge clk);
      fetch_pc = 32'h300;
      pkt = mk_pkt(1'b1, 8'h01, 8'h40, 2'b10, 4'd1, 26'h4, 1'b1, 32'h2000);
      @(negedge clk);
      pkt      = '0;
      fetch_pc = 32'h104;
      #1;
      check_count++;
      if (pred_taken !== 1'b1 || pred_pc !== 32'h2000)
         $display("FAIL weak_taken: got taken %0b pc %0h expected 1 2000", pred_taken, pred_pc);
      else pass_count++;
      // Weakly not-taken counter falls through
      @(negedge clk);
      fetch_pc = 32'h300;
      pkt = mk_pkt(1'b1, 8'h01, 8'h40, 2'b01, 4'd1, 26'h4, 1'b1, 32'h2000);
      @(negedge clk);
      pkt      = '0;
      fetch_pc = 32'h104;
      #1;
      check_count++;
      if (pred_taken !== 1'b0 || pred_pc !== 32'h108)
         $display("FAIL weak_not_taken: got taken %0b pc %0h expected 0 108", pred_taken, pred_pc);
      else pass_count++;
      // is_branch=0 leaves all state alone
      @(negedge clk);
      pkt = mk_pkt(1'b0, 8'hAA, 8'h40, 2'b11, 4'd1, 26'h0, 1'b0, 32'h0);
      @(negedge clk);
      pkt = '0;
      #1;
      check_count++;
      if (pred_bhr !== 8'h01 || pred_pht_entry !== 2'b01 || pred_pc !== 32'h108)
         $display("FAIL no_branch: got bhr %0h entry %0b pc %0h expected 01 01 108",
                  pred_bhr, pred_pht_entry, pred_pc);
      else pass_count++;
      $display("test_update_hit: counter boundaries and is_branch=0 done");
   endtask

   task automatic test_same_cycle();
      logic [1:0] exp_entry;
      logic       exp_taken;
`ifdef BP_BYPASS_EN
      exp_entry = 2'b11;
      exp_taken = 1'b1;
`else
      exp_entry = 2'b01;
      exp_taken = 1'b0;
`endif
      @(negedge clk);
      fetch_pc = 32'h104;
      pkt = mk_pkt(1'b1, 8'h01, 8'h40, 2'b11, 4'd1, 26'h4, 1'b1, 32'h2000);
      #1;
      check_count++;
      if (pred_pht_entry !== exp_entry)
         $display("FAIL same_cycle_entry: got %0b expected %0b", pred_pht_entry, exp_entry);
      else pass_count++;
      check_count++;
      if (pred_taken !== exp_taken)
         $display("FAIL same_cycle_taken: got %0b expected %0b", pred_taken, exp_taken);
      else pass_count++;
      @(negedge clk);
      pkt = '0;
      #1;
      check_count++;
      if (pred_pht_entry !== 2'b11 || pred_taken !== 1'b1)
         $display("FAIL after_same_cycle: got entry %0b taken %0b expected 11 1", pred_pht_entry, pred_taken);
      else pass_count++;
      // Update to unrelated entries does not disturb this lookup
      @(negedge clk);
      pkt = mk_pkt(1'b1, 8'h01, 8'h10, 2'b00, 4'd7, 26'h0, 1'b1, 32'h0);
      #1;
      check_count++;
      if (pred_pht_entry !== 2'b11 || pred_pc !== 32'h2000)
         $display("FAIL independent: got entry %0b pc %0h expected 11 2000", pred_pht_entry, pred_pc);
      else pass_count++;
      @(negedge clk);
      pkt = '0;
      $display("test_same_cycle: same-index and independent updates done");
   endtask

   task automatic test_reset_mid_init();
      int cyc;
      @(negedge clk);
      fetch_pc = 32'h104;
      reset    = 1'b0;
      #1;
      check_count++;
      if (bp_ready !== 1'b0 || pred_bhr !== 8'h00 || pred_taken !== 1'b0 || pred_pc !== 32'h108)
         $display("FAIL run_reset: got ready %0b bhr %0h taken %0b pc %0h expected 0 0 0 108",
                  bp_ready, pred_bhr, pred_taken, pred_pc);
      else pass_count++;
      @(negedge clk);
      reset = 1'b1;
      cyc   = 0;
      while (cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      reset = 1'b0;
      #1;
      check_count++;
      if (bp_ready !== 1'b0) $display("FAIL mid_init_reset_ready: got %0b expected 0", bp_ready);
      else pass_count++;
      @(negedge clk);
      reset = 1'b1;
      cyc   = 0;
      while (!bp_ready && cyc < 300) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check_count++;
      if (cyc !== 256) $display("FAIL restart_ready_cycle: got %0d expected 256", cyc);
      else pass_count++;
      $display("test_reset_mid_init: ready %0d cycles after release", cyc);
      // Make PHT[0x40] strongly taken via a different BTB slot; BTB[1] must be invalid
      @(negedge clk);
      pkt = mk_pkt(1'b1, 8'h01, 8'h40, 2'b11, 4'd5, 26'h0, 1'b0, 32'h0);
      @(negedge clk);
      pkt = '0;
      #1;
      check_count++;
      if (pred_pht_entry !== 2'b11 || pred_bhr !== 8'h01)
         $display("FAIL restart_update: got entry %0b bhr %0h expected 11 01", pred_pht_entry, pred_bhr);
      else pass_count++;
      check_count++;
      if (pred_taken !== 1'b0 || pred_pc !== 32'h108)
         $display("FAIL btb_valid_cleared: got taken %0b pc %0h expected 0 108", pred_taken, pred_pc);
      else pass_count++;
   endtask

   initial begin
      test_reset();
      test_init_sweep();
      test_update_hit();
      test_same_cycle();
      test_reset_mid_init();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
